// File: rtl/flippy_pkg.sv
// Shared constants and FSM state type for the BCD/binary score conversion path.
package flippy_pkg;

    localparam int unsigned BCD_DIGIT_W     = 4;
    localparam logic [3:0]  BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0]  BCD_CORR_SUB    = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd2bin_state_t;

    function automatic logic bcd_digit_invalid(input logic [3:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_nibble_correct.sv
// One BCD nibble correction step of reverse double-dabble: subtract 3 when >= 8.
module bcd_nibble_correct
    import flippy_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_nibble = i_nibble;
        if (i_nibble >= BCD_CORR_THRESH) begin
            o_nibble = i_nibble - BCD_CORR_SUB;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD to binary converter, one reverse double-dabble step per clock.
// Optional digit range check enabled by defining BCD_TO_BINARY_CHECK_EN.
module bcd_to_binary
    import flippy_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           hundreds,
    input  logic [3:0]           tens,
    input  logic [3:0]           ones,
    output logic                 busy,
    output logic                 valid,
    output logic [BIN_WIDTH-1:0] binary,
    output logic                 error
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int CAT_W = BCD_W + BIN_WIDTH;

    bcd2bin_state_t       r_state;
    logic [BCD_W-1:0]     r_bcd;
    logic [BIN_WIDTH-1:0] r_result;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_valid;
    logic [BIN_WIDTH-1:0] r_binary;

    logic [CAT_W-1:0]     w_shift;
    logic [BCD_W-1:0]     w_bcd_shifted;
    logic [BCD_W-1:0]     w_bcd_next;
    logic [BIN_WIDTH-1:0] w_result_next;
    logic [BCD_W-1:0]     w_capture;
    logic                 w_last;

    // The BCD LSB falls into the result MSB on each shift.
    assign w_shift       = {r_bcd, r_result} >> 1;
    assign w_bcd_shifted = w_shift[CAT_W-1 -: BCD_W];
    assign w_result_next = w_shift[BIN_WIDTH-1:0];
    assign w_capture     = {hundreds, tens, ones};
    assign w_last        = (r_cnt == CNT_W'(BIN_WIDTH - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_correct u_corr (
            .i_nibble (w_bcd_shifted[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_nibble (w_bcd_next[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_TO_BINARY_CHECK_EN
    logic r_error;
    logic r_err_pend;
    logic w_bad;

    assign w_bad = bcd_digit_invalid(hundreds) | bcd_digit_invalid(tens) |
                   bcd_digit_invalid(ones);
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bcd    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_binary <= '0;
`ifdef BCD_TO_BINARY_CHECK_EN
            r_error    <= 1'b0;
            r_err_pend <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef BCD_TO_BINARY_CHECK_EN
                    // A rejected request reports one edge after capture, without leaving IDLE.
                    if (r_err_pend) begin
                        r_err_pend <= 1'b0;
                        r_binary   <= '0;
                        r_error    <= 1'b1;
                        r_valid    <= 1'b1;
                    end else if (start && w_bad) begin
                        r_err_pend <= 1'b1;
                    end else
`endif
                    if (start) begin
                        r_bcd    <= w_capture;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd    <= w_bcd_next;
                    r_result <= w_result_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_binary <= w_result_next;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
`ifdef BCD_TO_BINARY_CHECK_EN
                        r_error  <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign binary = r_binary;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: expected results queued at start, checked on valid.
module tb_bcd_to_binary;

    typedef struct {
        int unsigned bin;
        int unsigned err;
        int unsigned lat;
        int unsigned cyc0;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hundreds = '0;
    logic [3:0] tens = '0;
    logic [3:0] ones = '0;
    logic       busy;
    logic       valid;
    logic [9:0] binary;
    logic       error;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned first_valid_cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    bcd_to_binary #(.DIGITS(3), .BIN_WIDTH(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .valid    (valid),
        .binary   (binary),
        .error    (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("binary", binary, mon_e.bin);
                check("error", error, mon_e.err);
                check("latency", cyc - mon_e.cyc0, mon_e.lat);
                check("busy_in_valid", busy, 0);
                last_valid_cyc = cyc;
            end
        end
    end

    // Caller must be at a negedge; returns 1 time unit after the accepting edge.
    task automatic do_start(input int unsigned h, input int unsigned t, input int unsigned o,
                            input bit is_err);
        exp_t e;
        hundreds = 4'(h);
        tens     = 4'(t);
        ones     = 4'(o);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        e.bin  = is_err ? 0 : h * 100 + t * 10 + o;
        e.err  = is_err ? 1 : 0;
        e.lat  = is_err ? 1 : 10;
        e.cyc0 = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        check("timeout_pending", sb.size(), 0);
    endtask

    initial begin
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_binary", binary, 0);
        check("rst_error", error, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 255 with busy held for the conversion window
        do_start(2, 5, 5, 1'b0);
        check("busy_after_e0", busy, 1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1 check("busy_conv", busy, 1);
        end
        wait_done();

        // back-to-back: second start driven in the valid cycle
        @(negedge clock);
        do_start(9, 9, 9, 1'b0);
        begin
            int unsigned k;
            k = 0;
            while (!valid && k < 20) begin
                @(negedge clock);
                k++;
            end
            check("b2b_first_valid_seen", valid, 1);
            first_valid_cyc = cyc;
        end
        do_start(0, 0, 0, 1'b0);
        wait_done();
        check("b2b_spacing", last_valid_cyc - first_valid_cyc, 11);

`ifdef BCD_TO_BINARY_CHECK_EN
        @(negedge clock);
        do_start(1, 10, 3, 1'b1);
        check("err_busy_e0", busy, 0);
        @(negedge clock);
        check("err_busy_e1", busy, 0);
        wait_done();
        @(negedge clock);
        do_start(0, 4, 2, 1'b0);
        wait_done();
`endif

        // start while busy (with changed inputs) must be ignored
        @(negedge clock);
        do_start(1, 2, 8, 1'b0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        hundreds = 4'd7;
        tens     = 4'd7;
        ones     = 4'd7;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done();
        repeat (15) @(negedge clock);
        check("ignored_start_hold", binary, 128);

        // asynchronous reset mid-conversion
        do_start(5, 0, 0, 1'b0);
        repeat (4) @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_binary", binary, 0);
        check("mid_rst_error", error, 0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (15) @(negedge clock);
        do_start(5, 0, 0, 1'b0);
        wait_done();

        // exhaustive sweep
        for (int v = 0; v < 1000; v++) begin
            do_start(v / 100, (v / 10) % 10, v % 10, 1'b0);
            wait_done();
        end

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

endmodule
